gray_conv_arbiter: RTL and testbench

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

---
 rtl/gray_conv_pkg.sv | 16 +
 rtl/gray2bin_comb.sv | 21 ++
 rtl/gray_conv_arbiter.sv | 110 +++++++++++
 tb/tb_gray_conv_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
`timescale 1ns/1ps
// gray_conv_pkg
// Shared definitions for the Gray-to-binary arbiter slice.
//   state_t   : output-slot state (EMPTY = no result held, FULL = result held)
//   REQ0/REQ1 : requester index constants, also used as the out_id encoding
package gray_conv_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/gray2bin_comb.sv
`timescale 1ns/1ps
// gray2bin_comb
// Purely combinational Gray-to-binary converter.
// Ports:
//   gray [N-1:0] in  : Gray-coded word
//   bin  [N-1:0] out : binary value; bin[i] is the XOR of gray[N-1:i]
module gray2bin_comb #(
    parameter int N = 3
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    // Each bit is the parity of all Gray bits at or above it. Written as a
    // reduction per bit rather than a ripple on bin itself, so no output bit
    // feeds back into the same vector.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
`timescale 1ns/1ps
// gray_conv_arbiter
// Two requesters share one Gray-to-binary converter; the converted word is
// registered in a single output slot tagged with the owning requester.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req0_valid/gray/ready    : requester 0 handshake and Gray word
//   req1_valid/gray/ready    : requester 1 handshake and Gray word
//   out_valid/bin/id/ready   : result slot handshake, binary value, owner
//   dbg_state                : current slot state (0 = EMPTY, 1 = FULL)
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high. Producers may not make ready depend on their data; here reqk_ready
// depends only on state, valids, out_ready, the grant pointer and rst. The
// result slot can take a new word when EMPTY, or when FULL and being drained
// in the same cycle (out_ready high), giving one result per cycle.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_gray,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_gray,
    output logic         req1_ready,
    output logic         out_valid,
    output logic [N-1:0] out_bin,
    output logic         out_id,
    input  logic         out_ready,
    output logic         dbg_state
);

    state_t       state;
    state_t       state_nxt;
    logic         last_grant;
    logic         can_accept;
    logic         grant_valid;
    logic         grant_id;
    logic [N-1:0] sel_gray;
    logic [N-1:0] conv_bin;

    // Grant and next-state logic
    always_comb begin
        can_accept  = 1'b0;
        grant_id    = REQ0;
        grant_valid = 1'b0;
        state_nxt   = state;

        // Reset cycle never accepts, so a word offered while rst is high is
        // not lost silently: the producer sees ready low and keeps it.
        can_accept = !rst && ((state == EMPTY) || out_ready);

        if (req0_valid && req1_valid) begin
            // Round-robin: the requester that did not win last time goes next.
            grant_id = (last_grant == REQ0) ? REQ1 : REQ0;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end else begin
            grant_id = REQ0;
        end

        grant_valid = can_accept && (req0_valid || req1_valid);

        case (state)
            EMPTY: begin
                if (grant_valid) state_nxt = FULL;
            end
            FULL: begin
                if (grant_valid)    state_nxt = FULL;
                else if (out_ready) state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign req0_ready = grant_valid && (grant_id == REQ0);
    assign req1_ready = grant_valid && (grant_id == REQ1);

    // Single converter instance fed by the granted requester's word.
    assign sel_gray = (grant_id == REQ1) ? req1_gray : req0_gray;

    gray2bin_comb #(.N(N)) u_conv (
        .gray (sel_gray),
        .bin  (conv_bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            out_bin    <= '0;
            out_id     <= REQ0;
            last_grant <= REQ1;  // so requester 0 wins the first contention
        end else begin
            state <= state_nxt;
            if (grant_valid) begin
                out_bin    <= conv_bin;
                out_id     <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    assign out_valid = (state == FULL);
    assign dbg_state = state;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
`timescale 1ns/1ps
module tb_gray_conv_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- N=3 main DUT ----------------
  logic       v0 = 0, v1 = 0, ordy = 0;
  logic [2:0] g0 = 0, g1 = 0;
  logic       r0, r1, ov, oid, dbg3;
  logic [2:0] obin;

  gray_conv_arbiter #(.N(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_gray(g0), .req0_ready(r0),
    .req1_valid(v1), .req1_gray(g1), .req1_ready(r1),
    .out_valid(ov), .out_bin(obin), .out_id(oid), .out_ready(ordy),
    .dbg_state(dbg3)
  );

  // ---------------- N=8 sweep DUT ----------------
  logic       s8_v0 = 0, s8_v1 = 0, s8_rdy = 1;
  logic [7:0] s8_g0 = 0, s8_g1 = 0;
  logic       s8_r0, s8_r1, s8_ov, s8_id, s8_dbg;
  logic [7:0] s8_bin;

  gray_conv_arbiter #(.N(8)) dut8 (
    .clk(clk), .rst(rst),
    .req0_valid(s8_v0), .req0_gray(s8_g0), .req0_ready(s8_r0),
    .req1_valid(s8_v1), .req1_gray(s8_g1), .req1_ready(s8_r1),
    .out_valid(s8_ov), .out_bin(s8_bin), .out_id(s8_id), .out_ready(s8_rdy),
    .dbg_state(s8_dbg)
  );

  // ---------------- N=1 sweep DUT ----------------
  logic s1_v0 = 0, s1_v1 = 0, s1_rdy = 1;
  logic [0:0] s1_g0 = 0, s1_g1 = 0;
  logic s1_r0, s1_r1, s1_ov, s1_id, s1_dbg;
  logic [0:0] s1_bin;

  gray_conv_arbiter #(.N(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(s1_v0), .req0_gray(s1_g0), .req0_ready(s1_r0),
    .req1_valid(s1_v1), .req1_gray(s1_g1), .req1_ready(s1_r1),
    .out_valid(s1_ov), .out_bin(s1_bin), .out_id(s1_id), .out_ready(s1_rdy),
    .dbg_state(s1_dbg)
  );

  // ---------------- reference helpers ----------------
  // Binary bit i is the parity of the Gray word shifted down by i.
  function automatic logic [31:0] g2b(input logic [31:0] g, input int w);
    logic [31:0] m;
    logic [31:0] b;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    b = '0;
    for (int i = 0; i < w; i++) b[i] = ^((g & m) >> i);
    return b;
  endfunction

  function automatic logic exp_grant(input logic a0, input logic a1, input logic last);
    if (a0 && a1) return ~last;
    return a1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model for N=3 DUT ----------------
  logic [3:0] exp_q[$];     // {id, bin}; at most one entry = the output slot
  logic       m_last = 1'b1;
  logic       model_on = 1'b0;

  always @(posedge clk) begin
    logic acc;
    logic gid;
    if (rst) begin
      exp_q.delete();
      m_last   = 1'b1;
      model_on = 1'b1;
    end else if (model_on) begin
      acc = (exp_q.size() == 0) || ordy;
      gid = exp_grant(v0, v1, m_last);
      if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
      if (acc && (v0 || v1)) begin
        exp_q.push_back({gid, g2b(32'(gid ? g1 : g0), 3)[2:0]});
        m_last = gid;
      end
    end
  end

  always @(negedge clk) begin
    logic acc;
    logic gid;
    logic e0;
    logic e1;
    if (model_on) begin
      acc = !rst && ((exp_q.size() == 0) || ordy);
      gid = exp_grant(v0, v1, m_last);
      e0  = acc && (v0 || v1) && !gid;
      e1  = acc && (v0 || v1) && gid;
      check("req0_ready", r0, e0);
      check("req1_ready", r1, e1);
      check("out_valid", ov, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("out_bin", obin, exp_q[0][2:0]);
        check("out_id", oid, exp_q[0][3]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rr, input logic a0, input logic [2:0] a0g,
                      input logic a1, input logic [2:0] a1g, input logic ar);
    @(posedge clk); #1;
    rst = rr; v0 = a0; g0 = a0g; v1 = a1; g1 = a1g; ordy = ar;
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // model pins for the boundary codes
    check("pin_111", g2b(32'd7, 3), 32'd5);
    check("pin_100", g2b(32'd4, 3), 32'd7);
    check("pin_000", g2b(32'd0, 3), 32'd0);

    step(1, 0, 3'b000, 0, 3'b000, 0);
    step(1, 0, 3'b000, 0, 3'b000, 0);
    step(0, 0, 3'b000, 0, 3'b000, 0);
    check("rst_valid", ov, 0);
    check("rst_bin", obin, 0);
    check("rst_id", oid, 0);

    // single word through requester 0
    step(0, 1, 3'b111, 0, 3'b000, 1);
    check("t33_r0", r0, 1);
    step(0, 0, 3'b000, 0, 3'b000, 1);
    check("t33_valid", ov, 1);
    check("t33_bin", obin, 3'b101);
    check("t33_id", oid, 0);

    // back-to-back round robin after a fresh reset
    step(1, 0, 3'b000, 0, 3'b000, 0);
    step(0, 1, 3'b100, 1, 3'b010, 1);
    check("t34_g0", {r1, r0}, 2'b01);
    step(0, 1, 3'b100, 1, 3'b010, 1);
    check("t34_g1", {r1, r0}, 2'b10);
    check("t34_o0", {oid, obin}, {1'b0, 3'b111});
    step(0, 1, 3'b100, 1, 3'b010, 1);
    check("t34_g2", {r1, r0}, 2'b01);
    check("t34_o1", {oid, obin}, {1'b1, 3'b011});
    step(0, 1, 3'b100, 1, 3'b010, 1);
    check("t34_g3", {r1, r0}, 2'b10);
    check("t34_o2", {oid, obin}, {1'b0, 3'b111});
    step(0, 1, 3'b100, 1, 3'b010, 1);
    check("t34_o3", {oid, obin}, {1'b1, 3'b011});

    // stall with both valid: slot holds 111/id0
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3'b100, 1, 3'b010, 0);
      check("t35_rdy", {r1, r0}, 2'b00);
      check("t35_out", {ov, oid, obin}, {1'b1, 1'b0, 3'b111});
    end

    // drain and refill from requester 1
    step(0, 0, 3'b000, 1, 3'b001, 1);
    check("t36_r1", {r1, r0}, 2'b10);
    step(0, 0, 3'b000, 0, 3'b000, 0);
    check("t36_out", {ov, oid, obin}, {1'b1, 1'b1, 3'b001});

    // reset while FULL with a valid requester
    step(1, 1, 3'b000, 0, 3'b000, 0);
    check("t37_rdy", {r1, r0}, 2'b00);
    step(0, 1, 3'b000, 1, 3'b110, 1);
    check("t37_valid", ov, 0);
    check("t37_bin", obin, 0);
    check("t37_first", {r1, r0}, 2'b01);
    step(0, 0, 3'b000, 0, 3'b000, 1);
    check("t37_out", {ov, oid, obin}, {1'b1, 1'b0, 3'b000});

    // N=3 sweep through each requester, checked by the scoreboard
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 3'(c), 0, 3'b000, 1);
      step(0, 0, 3'b000, 1, 3'(c), 1);
    end
    step(0, 0, 3'b000, 0, 3'b000, 1);

    // N=8 sweep
    for (int c = 0; c < 256; c++) begin
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        s8_v0 = (k == 0); s8_v1 = (k == 1); s8_g0 = 8'(c); s8_g1 = 8'(c);
        @(negedge clk);
        check("n8_ready", (k == 0) ? s8_r0 : s8_r1, 1);
        @(posedge clk); #1;
        s8_v0 = 0; s8_v1 = 0;
        @(negedge clk);
        check("n8_bin", s8_bin, g2b(32'(c), 8));
        check("n8_id", {s8_ov, s8_id}, {1'b1, k[0]});
      end
    end

    // N=1 sweep
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 2; k++) begin
        @(posedge clk); #1;
        s1_v0 = (k == 0); s1_v1 = (k == 1); s1_g0 = 1'(c); s1_g1 = 1'(c);
        @(negedge clk);
        check("n1_ready", (k == 0) ? s1_r0 : s1_r1, 1);
        @(posedge clk); #1;
        s1_v0 = 0; s1_v1 = 0;
        @(negedge clk);
        check("n1_bin", s1_bin, 32'(c));
        check("n1_id", {s1_ov, s1_id}, {1'b1, k[0]});
      end
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
